// File: rtl/spi_frame_decoder_if.sv
// Link between the SPI slave shifter and the frame decoder.
// The shifter (master modport) drives chip select and the received word;
// the decoder (slave modport) returns the response word for the next frame.
interface spi_frame_decoder_if;
    logic        cs;
    logic [15:0] rx_word;
    logic [15:0] tx_word;

    modport master (output cs, output rx_word, input tx_word);
    modport slave  (input cs, input rx_word, output tx_word);
endinterface

// File: rtl/spi_frame_decoder.sv
// spi_frame_decoder: consumes completed SPI frames, executes a register read
// or write against a local register file and loads the response word that
// the shifter returns during the following frame.
//
// Optional build macro SPI_FRAME_PARITY_EN: bit 14 of each frame is an even
// parity bit, the address shrinks to bits 13:8 and err_par_o is added.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for cs to fall (start of a frame)
// ACTIVE  | frame in progress, waiting for cs to rise
// CAPTURE | latch rx_word into the command register
// EXEC    | address/parity check, commit write, build response
// RESPOND | load tx_word, count the frame
module spi_frame_decoder #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    spi_frame_decoder_if.slave    spi,
    output logic                  wr_strobe_o,
    output logic [ADDR_W-1:0]     wr_addr_o,
    output logic [7:0]            wr_data_o,
    input  logic [ADDR_W-1:0]     app_addr_i,
    output logic [7:0]            app_rdata_o,
    output logic [15:0]           frame_cnt_o,
    output logic                  err_addr_o,
    output logic                  err_ovr_o,
`ifdef SPI_FRAME_PARITY_EN
    output logic                  err_par_o,
`endif
    input  logic                  err_clr_i
);

    localparam int          NREGS   = 1 << ADDR_W;
    localparam logic [31:0] NREGS_U = 32'(NREGS);

    typedef enum logic [2:0] {IDLE, ACTIVE, CAPTURE, EXEC, RESPOND} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   cs_s, cs_s_d_q, armed_q;
    logic                   rise, fall;

    logic [15:0]            cmd_q;
    logic [15:0]            resp_q, resp_d;
    logic [15:0]            tx_q;
    logic [15:0]            frame_cnt_q;
    logic [ADDR_W-1:0]      wr_addr_q;
    logic [7:0]             wr_data_q;
    logic                   err_addr_q, err_ovr_q;
    logic [7:0]             regs_q [NREGS];

    logic                   cmd_ld, exec_go, resp_ld, ovr_set;
    logic                   is_wr, addr_ok, par_ok;
    logic [6:0]             addr_field;
    logic [ADDR_W-1:0]      idx;
    logic                   wr_commit, addr_err_set;
    logic [15:0]            resp_raw;

    assign cs_s = cs_sync_q[SYNC_STAGES-1];
    assign rise = cs_s & ~cs_s_d_q;
    // Falls are only trusted once cs has been seen high after reset, so a
    // frame that was already under way when reset hit is never executed.
    assign fall = ~cs_s & cs_s_d_q & armed_q;

    // cs synchroniser, edge-detect delay and post-reset arming
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cs_sync_q <= '1;
            vld_q     <= '0;
            cs_s_d_q  <= 1'b1;
            armed_q   <= 1'b0;
        end else begin
            cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], spi.cs};
            vld_q     <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            cs_s_d_q  <= cs_s;
            armed_q   <= armed_q | (vld_q[SYNC_STAGES-1] & cs_s);
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state and control strobes
    always_comb begin
        state_d = state_q;
        cmd_ld  = 1'b0;
        exec_go = 1'b0;
        resp_ld = 1'b0;
        ovr_set = 1'b0;
        case (state_q)
            IDLE:    if (fall) state_d = ACTIVE;
            ACTIVE:  if (rise) state_d = CAPTURE;
            CAPTURE: begin
                if (fall) begin ovr_set = 1'b1; state_d = ACTIVE; end
                else      begin cmd_ld  = 1'b1; state_d = EXEC;   end
            end
            EXEC: begin
                if (fall) begin ovr_set = 1'b1; state_d = ACTIVE;  end
                else      begin exec_go = 1'b1; state_d = RESPOND; end
            end
            RESPOND: begin
                if (fall) begin ovr_set = 1'b1; state_d = ACTIVE; end
                else      begin resp_ld = 1'b1; state_d = IDLE;   end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command decode and response formation
    always_comb begin
        is_wr = cmd_q[15];
`ifdef SPI_FRAME_PARITY_EN
        addr_field = {1'b0, cmd_q[13:8]};
        par_ok     = ~^cmd_q;
`else
        addr_field = cmd_q[14:8];
        par_ok     = 1'b1;
`endif
        addr_ok  = ({25'd0, addr_field} < NREGS_U);
        idx      = addr_field[ADDR_W-1:0];
        resp_raw = is_wr ? {1'b0, addr_field, cmd_q[7:0]}
                         : {1'b1, addr_field, regs_q[idx]};
`ifdef SPI_FRAME_PARITY_EN
        resp_raw[14] = ^{resp_raw[15], resp_raw[13:0]};
`endif
        if (!par_ok)       resp_d = 16'hFE00;
        else if (!addr_ok) resp_d = 16'hFF00;
        else               resp_d = resp_raw;
        wr_commit    = exec_go & is_wr & addr_ok & par_ok;
        addr_err_set = exec_go & ~addr_ok & par_ok;
    end

    // Command/response/output registers and sticky error flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_q       <= '0;
            resp_q      <= '0;
            tx_q        <= '0;
            frame_cnt_q <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_addr_q  <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            if (cmd_ld)  cmd_q  <= spi.rx_word;
            if (exec_go) resp_q <= resp_d;
            if (resp_ld) begin
                tx_q        <= resp_q;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (wr_commit) begin
                wr_addr_q <= idx;
                wr_data_q <= cmd_q[7:0];
            end
            err_addr_q <= addr_err_set ? 1'b1 : (err_clr_i ? 1'b0 : err_addr_q);
            err_ovr_q  <= ovr_set      ? 1'b1 : (err_clr_i ? 1'b0 : err_ovr_q);
        end
    end

`ifdef SPI_FRAME_PARITY_EN
    logic err_par_q;

    // Sticky parity error, set wins over clear
    always_ff @(posedge clk_i) begin
        if (rst_i) err_par_q <= 1'b0;
        else       err_par_q <= (exec_go & ~par_ok) ? 1'b1
                                : (err_clr_i ? 1'b0 : err_par_q);
    end

    assign err_par_o = err_par_q;
`endif

    // Register file, written only by a committed write
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_commit) begin
            regs_q[idx] <= cmd_q[7:0];
        end
    end

    // During the strobe cycle the write port shows the new access; it then
    // holds that access until the next write.
    assign wr_strobe_o = wr_commit;
    assign wr_addr_o   = wr_commit ? idx        : wr_addr_q;
    assign wr_data_o   = wr_commit ? cmd_q[7:0] : wr_data_q;
    assign app_rdata_o = regs_q[app_addr_i];
    assign frame_cnt_o = frame_cnt_q;
    assign err_addr_o  = err_addr_q;
    assign err_ovr_o   = err_ovr_q;
    assign spi.tx_word = tx_q;

endmodule
